// File: rtl/rxdata_pack.sv
// rxdata_pack: packs 16-bit DQ FIFO entries into 32-bit little-endian words
// with byte strobes and a last flag, then flushes the DQ FIFO at transfer end.
module rxdata_pack #(
    parameter int LEN_WIDTH = 12
) (
    input  logic                 mem_clk,
    input  logic                 reset_n,
    input  logic                 xfer_start,
    input  logic [LEN_WIDTH-1:0] xfer_len,
    input  logic                 rcv_dqfifo_empty,
    input  logic [15:0]          rcv_dqfifo_dout,
    output logic                 rcv_dqfifo_rd_en,
    output logic                 rcv_dq_fifo_flush_en,
    input  logic                 rcv_dq_fifo_flush_done,
    output logic                 rx_data_valid,
    output logic [31:0]          rx_data,
    output logic [3:0]           rx_data_strb,
    output logic                 rx_data_last,
    input  logic                 rx_data_ready,
    output logic                 xfer_busy,
    output logic                 xfer_done
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RECV       = 3'd1;
    localparam logic [2:0] ST_FLUSH      = 3'd2;
    localparam logic [2:0] ST_WAIT_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    logic [2:0]           state;
    logic [LEN_WIDTH-1:0] reads_left;
    logic [LEN_WIDTH:0]   len_plus_one;
    logic [LEN_WIDTH-1:0] reads_init;
    logic [3:0]           last_strb;
    logic [3:0]           start_strb;
    logic [15:0]          asm_data;
    logic                 asm_lo;
    logic                 completing;
    logic                 out_free;
    logic                 pop;
    logic                 word_last;
    logic [3:0]           word_strb;
    logic [31:0]          word_raw;
    logic [31:0]          word_masked;

    // Entry count for a new transfer is ceil(len/2); odd lengths round up.
    assign len_plus_one = {1'b0, xfer_len} + {{LEN_WIDTH{1'b0}}, 1'b1};
    assign reads_init   = len_plus_one[LEN_WIDTH:1];

    // Strobe of the final word depends only on the byte count modulo 4.
    always_comb begin
        start_strb = 4'b1111;
        case (xfer_len[1:0])
            2'd1:    start_strb = 4'b0001;
            2'd2:    start_strb = 4'b0011;
            2'd3:    start_strb = 4'b0111;
            default: start_strb = 4'b1111;
        endcase
    end

    // A pop completes a word when the low half is already held or this is the final entry.
    always_comb begin
        completing  = asm_lo || (reads_left == ONE);
        out_free    = !rx_data_valid || rx_data_ready;
        pop         = (state == ST_RECV) && !rcv_dqfifo_empty && (reads_left != '0)
                      && (!completing || out_free);
        word_last   = (reads_left == ONE);
        word_strb   = word_last ? last_strb : 4'b1111;
        word_raw    = asm_lo ? {rcv_dqfifo_dout, asm_data} : {16'h0000, rcv_dqfifo_dout};
        word_masked = word_raw & {{8{word_strb[3]}}, {8{word_strb[2]}},
                                  {8{word_strb[1]}}, {8{word_strb[0]}}};
    end

    assign rcv_dqfifo_rd_en     = pop;
    assign rcv_dq_fifo_flush_en = (state == ST_FLUSH);
    assign xfer_busy            = (state != ST_IDLE);
    assign xfer_done            = (state == ST_DONE);

    // Transfer sequencing, entry counting and the low-half assembly register.
    always_ff @(posedge mem_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            reads_left <= '0;
            last_strb  <= 4'b0000;
            asm_data   <= 16'h0000;
            asm_lo     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer_start) begin
                        reads_left <= reads_init;
                        last_strb  <= start_strb;
                        asm_lo     <= 1'b0;
                        state      <= (xfer_len == '0) ? ST_FLUSH : ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (pop) begin
                        reads_left <= reads_left - ONE;
                        if (completing) begin
                            asm_lo <= 1'b0;
                        end else begin
                            asm_data <= rcv_dqfifo_dout;
                            asm_lo   <= 1'b1;
                        end
                    end
                    if (rx_data_valid && rx_data_ready && rx_data_last) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_WAIT_FLUSH;
                end
                ST_WAIT_FLUSH: begin
                    if (rcv_dq_fifo_flush_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output word register: loads on a completing pop, holds while stalled.
    always_ff @(posedge mem_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_valid <= 1'b0;
            rx_data       <= 32'h0000_0000;
            rx_data_strb  <= 4'b0000;
            rx_data_last  <= 1'b0;
        end else if (pop && completing) begin
            rx_data_valid <= 1'b1;
            rx_data       <= word_masked;
            rx_data_strb  <= word_strb;
            rx_data_last  <= word_last;
        end else if (rx_data_valid && rx_data_ready) begin
            rx_data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rxdata_pack.sv
// tb_rxdata_pack: randomized and directed checks of rxdata_pack against a
// byte-stream model of the expected output words.
module tb_rxdata_pack;

    logic        mem_clk;
    logic        reset_n;
    logic        xfer_start;
    logic [11:0] xfer_len;
    logic        rcv_dqfifo_empty;
    logic [15:0] rcv_dqfifo_dout;
    logic        rcv_dqfifo_rd_en;
    logic        rcv_dq_fifo_flush_en;
    logic        rcv_dq_fifo_flush_done;
    logic        rx_data_valid;
    logic [31:0] rx_data;
    logic [3:0]  rx_data_strb;
    logic        rx_data_last;
    logic        rx_data_ready;
    logic        xfer_busy;
    logic        xfer_done;

    rxdata_pack #(.LEN_WIDTH(12)) dut (
        .mem_clk               (mem_clk),
        .reset_n               (reset_n),
        .xfer_start            (xfer_start),
        .xfer_len              (xfer_len),
        .rcv_dqfifo_empty      (rcv_dqfifo_empty),
        .rcv_dqfifo_dout       (rcv_dqfifo_dout),
        .rcv_dqfifo_rd_en      (rcv_dqfifo_rd_en),
        .rcv_dq_fifo_flush_en  (rcv_dq_fifo_flush_en),
        .rcv_dq_fifo_flush_done(rcv_dq_fifo_flush_done),
        .rx_data_valid         (rx_data_valid),
        .rx_data               (rx_data),
        .rx_data_strb          (rx_data_strb),
        .rx_data_last          (rx_data_last),
        .rx_data_ready         (rx_data_ready),
        .xfer_busy             (xfer_busy),
        .xfer_done             (xfer_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int rmode = 0;
    int emode = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] stim_q[$];
    logic [36:0] exp_q[$];
    logic [31:0] got_data[$];
    logic [3:0]  got_strb[$];

    int pops, flush_cnt, done_cnt;
    int flush_cyc, fd_cyc, done_cyc, hs_last_cyc, start_cyc;
    logic rd_s = 1'b0;
    logic flush_s = 1'b0;
    logic prev_stall = 1'b0;
    logic [36:0] prev_word;
    int stall_pops = 0;

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    // Cycle counter: value during a cycle is the index of that cycle.
    initial forever begin
        @(posedge mem_clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: pops/flushes at the edge, presents the head entry just after it.
    initial begin
        logic gap;
        rcv_dqfifo_empty = 1'b1;
        rcv_dqfifo_dout  = 16'h0000;
        forever begin
            @(posedge mem_clk);
            if (flush_s) fifo_q.delete();
            else if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #1;
            gap = 1'b0;
            if (emode == 1) gap = cyc[0];
            else if (emode == 2) gap = ($urandom_range(0, 2) == 0);
            rcv_dqfifo_empty = (fifo_q.size() == 0) || gap;
            rcv_dqfifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 16'($urandom);
        end
    end

    // Downstream ready pattern.
    initial begin
        rx_data_ready = 1'b1;
        forever begin
            @(posedge mem_clk);
            #1;
            if (rmode == 0) rx_data_ready = 1'b1;
            else if (rmode == 1) rx_data_ready = ($urandom_range(0, 3) != 0);
            else rx_data_ready = ((cyc % 6) == 5);
        end
    end

    // Flush responder: completes the flush 1..3 cycles after the request.
    initial begin
        int d;
        rcv_dq_fifo_flush_done = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (reset_n && rcv_dq_fifo_flush_en) begin
                d = $urandom_range(1, 3);
                repeat (d) @(posedge mem_clk);
                #1 rcv_dq_fifo_flush_done = 1'b1;
                @(posedge mem_clk);
                #1 rcv_dq_fifo_flush_done = 1'b0;
            end
        end
    end

    // Compare process: sampled mid-cycle, checks every handshake and stall.
    always @(negedge mem_clk) begin
        rd_s    = rcv_dqfifo_rd_en;
        flush_s = rcv_dq_fifo_flush_en;
        if (!reset_n) begin
            prev_stall = 1'b0;
            stall_pops = 0;
        end else begin
            if (prev_stall)
                checkOutput("hold_stable", {rx_data_valid, rx_data_last, rx_data_strb, rx_data},
                            {1'b1, prev_word});
            if (rx_data_valid && !rx_data_ready) begin
                if (rcv_dqfifo_rd_en) begin
                    stall_pops++;
                    checkOutput("stall_pops_le1", 64'(stall_pops <= 1), 64'd1);
                end
            end else begin
                stall_pops = 0;
            end
            if (rcv_dqfifo_rd_en) begin
                pops++;
                checkOutput("rd_en_while_empty", rcv_dqfifo_empty, 1'b0);
            end
            if (rx_data_valid && rx_data_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", {rx_data_last, rx_data_strb, rx_data}, 64'd0);
                end else begin
                    checkOutput("word", {rx_data_last, rx_data_strb, rx_data}, exp_q.pop_front());
                end
                got_data.push_back(rx_data);
                got_strb.push_back(rx_data_strb);
                if (rx_data_last) hs_last_cyc = cyc;
            end
            if (rcv_dq_fifo_flush_en) begin
                flush_cnt++;
                flush_cyc = cyc;
            end
            if (rcv_dq_fifo_flush_done) fd_cyc = cyc;
            if (xfer_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = rx_data_valid && !rx_data_ready;
            prev_word  = {rx_data_last, rx_data_strb, rx_data};
        end
    end

    // Runs one transfer of len bytes using entries from stim_q (plus extras already in it).
    task automatic applyStimulus(input int len, input int rm, input int em, input bit second_start);
        int   n;
        int   nwords;
        logic [7:0]  bytes[$];
        logic [31:0] d;
        logic [3:0]  s;
        int   t;
        n = (len + 1) / 2;
        foreach (stim_q[i]) begin
            fifo_q.push_back(stim_q[i]);
            if (i < n) begin
                bytes.push_back(stim_q[i][7:0]);
                bytes.push_back(stim_q[i][15:8]);
            end
        end
        stim_q.delete();
        nwords = (len + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            d = 32'h0;
            s = 4'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < len) begin
                    d[8*b +: 8] = bytes[4 * w + b];
                    s[b] = 1'b1;
                end
            end
            exp_q.push_back({(w == nwords - 1), s, d});
        end
        rmode = rm;
        emode = em;
        pops = 0; flush_cnt = 0; done_cnt = 0;
        flush_cyc = -1; fd_cyc = -1; done_cyc = -1; hs_last_cyc = -1;
        got_data.delete();
        got_strb.delete();

        @(posedge mem_clk);
        #2;
        xfer_start = 1'b1;
        xfer_len   = 12'(len);
        start_cyc  = cyc;
        @(posedge mem_clk);
        #2;
        xfer_start = second_start;
        xfer_len   = 12'd8;
        @(negedge mem_clk);
        checkOutput("busy_after_start", xfer_busy, 1'b1);
        @(posedge mem_clk);
        #2;
        xfer_start = 1'b0;

        for (t = 0; t < 3000 && done_cnt == 0; t++) @(posedge mem_clk);
        checkOutput("done_seen", 64'(done_cnt != 0), 64'd1);
        @(negedge mem_clk);
        checkOutput("idle_after_done", {xfer_busy, xfer_done}, 2'b00);
        checkOutput("all_words_out", exp_q.size(), 64'd0);
        checkOutput("pop_count", pops, n);
        checkOutput("flush_count", flush_cnt, 64'd1);
        checkOutput("flush_timing", flush_cyc, (len == 0) ? start_cyc + 1 : hs_last_cyc + 1);
        checkOutput("done_timing", done_cyc, fd_cyc + 1);
        checkOutput("done_count", done_cnt, 64'd1);
        exp_q.delete();
    endtask

    initial begin
        int len;
        reset_n    = 1'b0;
        xfer_start = 1'b0;
        xfer_len   = 12'd0;
        #1;
        checkOutput("reset_outputs",
                    {rcv_dqfifo_rd_en, rcv_dq_fifo_flush_en, rx_data_valid, rx_data,
                     rx_data_strb, rx_data_last, xfer_busy, xfer_done}, 64'd0);
        repeat (3) @(posedge mem_clk);
        #2 reset_n = 1'b1;

        // Directed: 8 bytes, continuous ready.
        stim_q = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        applyStimulus(8, 0, 0, 1'b0);
        checkOutput("t8_nwords", got_data.size(), 64'd2);
        checkOutput("t8_word0", (got_data.size() > 0) ? got_data[0] : 32'hx, 32'h03020100);
        checkOutput("t8_word1", (got_data.size() > 1) ? got_data[1] : 32'hx, 32'h07060504);

        // Directed: 5 bytes, byte 0x15 discarded.
        stim_q = '{16'h1110, 16'h1312, 16'h1514};
        applyStimulus(5, 0, 0, 1'b0);
        checkOutput("t5_word0", (got_data.size() > 0) ? got_data[0] : 32'hx, 32'h13121110);
        checkOutput("t5_word1", (got_data.size() > 1) ? got_data[1] : 32'hx, 32'h00000014);
        checkOutput("t5_strb1", (got_strb.size() > 1) ? got_strb[1] : 4'hx, 4'h1);

        // Backpressure: ready low five of every six cycles.
        for (int i = 0; i < 8; i++) stim_q.push_back(16'($urandom));
        applyStimulus(16, 2, 0, 1'b0);

        // Empty toggling every other cycle.
        for (int i = 0; i < 6; i++) stim_q.push_back(16'($urandom));
        applyStimulus(12, 0, 1, 1'b0);

        // Zero length with stale FIFO content and a second start while busy.
        stim_q = '{16'hAAAA, 16'hBBBB};
        applyStimulus(0, 0, 0, 1'b1);
        repeat (3) @(posedge mem_clk);
        @(negedge mem_clk);
        checkOutput("zero_len_stays_idle", {xfer_busy, rx_data_valid}, 2'b00);

        // Reset after the first pop of an 8-byte transfer.
        for (int i = 0; i < 4; i++) fifo_q.push_back(16'($urandom));
        rmode = 0; emode = 0; pops = 0;
        @(posedge mem_clk);
        #2 xfer_start = 1'b1; xfer_len = 12'd8;
        @(posedge mem_clk);
        #2 xfer_start = 1'b0;
        for (int t = 0; t < 20 && pops == 0; t++) @(posedge mem_clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midxfer_reset_outputs",
                    {rcv_dqfifo_rd_en, rcv_dq_fifo_flush_en, rx_data_valid, rx_data,
                     rx_data_strb, rx_data_last, xfer_busy, xfer_done}, 64'd0);
        fifo_q.delete();
        repeat (2) @(posedge mem_clk);
        #2 reset_n = 1'b1;
        stim_q = '{16'h2120, 16'h2322, 16'h2524, 16'h2726};
        applyStimulus(8, 1, 0, 1'b0);
        checkOutput("post_reset_word0", (got_data.size() > 0) ? got_data[0] : 32'hx, 32'h23222120);

        // Randomized transfers.
        for (int k = 0; k < 25; k++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            for (int i = 0; i < (len + 1) / 2 + $urandom_range(0, 2); i++)
                stim_q.push_back(16'($urandom));
            applyStimulus(len, 1, 2, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rxdata_pack.md
# rxdata_pack

Receive-path packing stage downstream of the DQ capture interface. Pops 16-bit entries from the receive DQ FIFO, assembles them into 32-bit little-endian words with byte strobes and a last flag, and presents them on a valid/ready stream toward the AXI read-data path. When a transfer's byte count has been delivered, it flushes the DQ FIFO, waits for the flush to complete, and reports completion.

## Interface
- LEN_WIDTH, 12, width of the transfer byte count (max 2^LEN_WIDTH-1 bytes)

- mem_clk  in  1  memory-domain clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- xfer_start  in  1  one-cycle pulse; latches xfer_len, starts a transfer
- xfer_len  in  LEN_WIDTH  transfer length in bytes; sampled only with xfer_start
- rcv_dqfifo_empty  in  1  DQ FIFO empty
- rcv_dqfifo_dout  in  16  DQ FIFO head entry (first-word-fall-through; valid while !empty)
- rcv_dqfifo_rd_en  out  1  pop head entry (combinational)
- rcv_dq_fifo_flush_en  out  1  one-cycle flush request to DQ FIFO
- rcv_dq_fifo_flush_done  in  1  flush-complete pulse
- rx_data_valid  out  1  output word valid
- rx_data  out  32  output word; byte 0 in [7:0]
- rx_data_strb  out  4  per-byte valid
- rx_data_last  out  1  final word of transfer
- rx_data_ready  in  1  downstream accept
- xfer_busy  out  1  transfer in progress
- xfer_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RECV, FLUSH, WAIT_FLUSH, DONE.
- IDLE: on xfer_start, load bytes_left = xfer_len and reads_left = ceil(xfer_len/2). Go to RECV, or to FLUSH if xfer_len == 0. xfer_busy = 1 in every state except IDLE.
- xfer_start outside IDLE is ignored.
- Byte order: rcv_dqfifo_dout[7:0] is the earlier byte. The first entry of a word fills rx_data[15:0] and the second fills [31:16].
- Packing uses a 16-bit assembly half-register with flag asm_lo, plus one output register.
  - A pop is "completing" when asm_lo = 1 or reads_left == 1. Otherwise the pop stores into asm_lo.
- rcv_dqfifo_rd_en = (state == RECV) && !rcv_dqfifo_empty && reads_left != 0 && (!completing || out_free), where out_free = !rx_data_valid || rx_data_ready.
- A completing pop loads the output register and sets rx_data_valid, then clears asm_lo.
  - A word completed by the last pop with asm_lo = 0 uses the entry as the low half, and the upper half is zero.
- Strobe: 4'b1111 for every non-last word. For the last word, strobe is set by xfer_len mod 4: 1→0001, 2→0011, 3→0111, 0→1111. Bytes with strobe 0 are driven as 0.
  - For odd xfer_len, the final FIFO entry's byte [15:8] is discarded.
- rx_data_last = 1 on the word holding the final byte.
- The output register holds data, strb and last stable while valid && !ready.
- When the last word handshakes (valid && ready && last), go to FLUSH.
- FLUSH: rcv_dq_fifo_flush_en = 1 for exactly one cycle, then WAIT_FLUSH.
- WAIT_FLUSH: on rcv_dq_fifo_flush_done go to DONE. rd_en stays 0 in this state.
- DONE: xfer_done = 1 for one cycle, then IDLE.
- Reset mid-transfer: all state returns to IDLE, and a partial word is discarded without being emitted.

## Timing
- Reset values: rcv_dqfifo_rd_en = 0, rcv_dq_fifo_flush_en = 0, rx_data_valid = 0, rx_data = 0, rx_data_strb = 0, rx_data_last = 0, xfer_busy = 0, xfer_done = 0.
- xfer_start sampled at edge N: state = RECV from cycle N+1, and rd_en may first assert in N+1.
- Latency: pops in cycles C and C+1 give rx_data_valid = 1 in C+2.
- Throughput: one pop per cycle and one word per two cycles. Back-to-back words are sustained when ready is held high.
- Backpressure: while valid && !ready, at most one non-completing pop (into asm_lo) occurs, and then rd_en stays 0.
- An empty FIFO only stalls; there is no timeout.
- Last handshake at edge M: flush_en = 1 in cycle M+1.
- flush_done sampled at edge K: xfer_done = 1 in cycle K+1, and xfer_busy = 0 from K+2.
- A new xfer_start is accepted from cycle K+2.

## Test plan
- xfer_len = 8, FIFO pre-filled with 0x0100, 0x0302, 0x0504, 0x0706, ready = 1 -> two words, 0x03020100 (strb F) then 0x07060504 (strb F, last). Then one flush_en pulse, and xfer_done one cycle after flush_done.
- xfer_len = 5, entries 0x1110, 0x1312, 0x1514 -> words 0x13121110 (strb F), then 0x00000014 (strb 1, last). Byte 0x15 is dropped, and exactly 3 pops occur.
- xfer_len = 16 with ready low for 5 cycles on each word -> rx_data stays stable while stalled, at most one extra pop per stall, and no lost or duplicated bytes.
- FIFO empty toggling every other cycle during xfer_len = 12 -> rd_en is only asserted when not empty, and the three words are correct and in order.
- xfer_len = 0 -> no rd_en and no valid; flush_en pulse one cycle after start, then xfer_done. A second xfer_start while busy is ignored.
- reset_n low after the first pop of an xfer_len = 8 transfer -> all outputs return to reset values immediately. A fresh transfer afterwards produces correct words.
